// File: rtl/cic3_sample_buffer.sv
// cic3_sample_buffer
//   Sits behind the CIC3 decimator. It detects each new decimated output word
//   and drops the first DISCARD words after start-up while the filter settles.
//   Each remaining word is converted to a saturated signed OUT_BITS sample.
//   Samples are queued in a first-word-fall-through FIFO, and the consumer
//   reads them with a valid/ready handshake.
//
// Ports
//   clk          modulator-rate clock (same clock as the CIC3)
//   reset_n      asynchronous active-low reset
//   cic_out      CIC3 output word, unsigned, mid-scale = 2^(CIC_BITS-2)
//   cic_div_clk  CIC3 decimated clock; rising edge marks a new cic_out
//   enable       run/stop; low returns to IDLE and flushes the FIFO
//   rd_ready     consumer takes rd_data this cycle
//   clr_ovf      pulse clearing the sticky overflow flag
//   rd_data      signed sample at the FIFO head (0 while empty)
//   rd_valid     FIFO holds at least one sample
//   fifo_count   number of stored samples, 0..DEPTH
//   ovf          sticky: a sample was dropped because the FIFO was full
module cic3_sample_buffer #(
  parameter int CIC_BITS = 25,
  parameter int OUT_BITS = 16,
  parameter int SHIFT    = 8,
  parameter int DEPTH    = 8,
  parameter int DISCARD  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CIC_BITS-1:0]       cic_out,
  input  logic                      cic_div_clk,
  input  logic                      enable,
  input  logic                      rd_ready,
  input  logic                      clr_ovf,
  output logic [OUT_BITS-1:0]       rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DISCARD + 1);
  localparam int WW = CIC_BITS + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic signed [WW-1:0] ONE     = {{(WW-1){1'b0}}, 1'b1};
  localparam logic signed [WW-1:0] MID     = ONE <<< (CIC_BITS - 2);
  localparam logic signed [WW-1:0] SAT_MAX = (ONE <<< (OUT_BITS - 1)) - ONE;
  localparam logic signed [WW-1:0] SAT_MIN = -(ONE <<< (OUT_BITS - 1));

  // ---------------------------------------------------------------- edge detect
  logic div_q_reg, div_q2_reg;
  logic new_word, capture;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q_reg  <= 1'b0;
      div_q2_reg <= 1'b0;
    end else begin
      div_q_reg  <= cic_div_clk;
      div_q2_reg <= div_q_reg;
    end
  end

  assign new_word = div_q_reg & ~div_q2_reg;
  // A word arriving while disabled is discarded rather than queued.
  assign capture  = new_word & enable;

  // ------------------------------------------------------------------------ FSM
  logic [1:0]    state_reg;
  logic [DW-1:0] disc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      disc_reg  <= '0;
    end else if (!enable) begin
      state_reg <= ST_IDLE;
      disc_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_reg <= ST_SETTLE;
          disc_reg  <= '0;
        end
        ST_SETTLE: begin
          if (capture) begin
            disc_reg <= disc_reg + DW'(1);
            if (disc_reg == DW'(DISCARD - 1)) state_reg <= ST_RUN;
          end
        end
        ST_RUN:  state_reg <= ST_RUN;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- conversion
  // Each intermediate is one bit wider than the input, so removing mid-scale
  // cannot wrap. The arithmetic shift rounds toward minus infinity.
  logic signed [WW-1:0] s_val, t_val;
  logic [OUT_BITS-1:0]  sample;

  assign s_val = $signed({1'b0, cic_out}) - MID;
  assign t_val = s_val >>> SHIFT;

  always_comb begin
    sample = t_val[OUT_BITS-1:0];
    if (t_val > SAT_MAX)      sample = SAT_MAX[OUT_BITS-1:0];
    else if (t_val < SAT_MIN) sample = SAT_MIN[OUT_BITS-1:0];
  end

  // ----------------------------------------------------------------------- FIFO
  logic [OUT_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic                ovf_reg;
  logic                wr_req, full, pop, wr_ok, drop;

  assign wr_req = capture & (state_reg == ST_RUN);
  assign full   = (count_reg == CW'(DEPTH));
  assign pop    = rd_valid & rd_ready;
  // When the FIFO is full, a pop in the same cycle frees the head slot for the new sample.
  assign wr_ok  = wr_req & (~full | pop);
  assign drop   = wr_req & full & ~pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (!enable || state_reg == ST_IDLE) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (wr_ok && !pop)      count_reg <= count_reg + CW'(1);
      else if (!wr_ok && pop) count_reg <= count_reg - CW'(1);
    end
  end

  // The storage is not reset. Its contents are only visible through rd_data,
  // and rd_data is gated by rd_valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= sample;
  end

  // A drop sets the flag. If a drop and clr_ovf arrive in the same cycle, the drop wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ovf_reg <= 1'b0;
    else if (drop)    ovf_reg <= 1'b1;
    else if (clr_ovf) ovf_reg <= 1'b0;
  end

  assign rd_valid   = (count_reg != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_count = count_reg;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_cic3_sample_buffer.sv
// Directed testbench for cic3_sample_buffer. Each task drives one scenario
// and checks its own results. The task sequence is called from one initial block.
module tb_cic3_sample_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [24:0] cic_out = 25'h0;
  logic        cic_div_clk;
  logic        enable = 1'b0;
  logic        rd_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [3:0]  fifo_count;
  logic        ovf;

  logic        use_cnt = 1'b0;
  logic        div_man = 1'b0;
  logic [7:0]  div_cnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [24:0] MIDW = 25'h0800000;

  cic3_sample_buffer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cic_out    (cic_out),
    .cic_div_clk(cic_div_clk),
    .enable     (enable),
    .rd_ready   (rd_ready),
    .clr_ovf    (clr_ovf),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // An 8-bit divider models the CIC3 decimated clock: one word every 256 cycles.
  always @(posedge clk) begin
    if (!reset_n) div_cnt <= 8'd0;
    else          div_cnt <= div_cnt + 8'd1;
  end
  assign cic_div_clk = use_cnt ? div_cnt[7] : div_man;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decimated word by hand. The capture happens on the second edge.
  // clr_ovf and rd_ready can optionally be held on that capture edge.
  task automatic send(input logic [24:0] v, input logic clr, input logic rdy);
    cic_out = v;
    div_man = 1'b1;
    tick();
    clr_ovf  = clr;
    rd_ready = rdy;
    tick();
    clr_ovf  = 1'b0;
    rd_ready = 1'b0;
    div_man  = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  function automatic logic [24:0] word_of(input int k);
    return MIDW + 25'(k * 256);
  endfunction

  task automatic test_reset();
    enable  = 1'b1;
    cic_out = MIDW;
    use_cnt = 1'b1;
    #3;
    n_cmp++;
    if ({rd_valid, rd_data, fifo_count, ovf} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%0b data=%h count=%0d ovf=%0b, want all 0",
               rd_valid, rd_data, fifo_count, ovf);
    end
    tick(); tick(); tick();
    reset_n = 1'b1;
    n_cmp++;
    if ({rd_valid, fifo_count, ovf} !== 6'h0) begin
      n_err++;
      $display("FAIL reset_release: got valid=%0b count=%0d ovf=%0b, want 0", rd_valid, fifo_count, ovf);
    end
  endtask

  // With the free-running divider, the first valid sample should appear
  // exactly 2 clk cycles after the 4th rising edge of the decimated clock.
  task automatic test_startup(input string tag);
    int   rises = 0;
    int   rise4 = -1;
    int   first_valid = -1;
    logic prev = 1'b0;
    for (int c = 0; c < 1400 && first_valid < 0; c++) begin
      tick();
      if (cic_div_clk && !prev) begin
        rises++;
        if (rises == 4) rise4 = c;
      end
      prev = cic_div_clk;
      if (rd_valid) first_valid = c;
    end
    n_cmp++;
    if (rise4 < 0 || first_valid != rise4 + 2) begin
      n_err++;
      $display("FAIL %s_latency: first rd_valid at cycle %0d, want %0d (4th rise + 2)",
               tag, first_valid, rise4 + 2);
    end
    n_cmp++;
    if (rd_data !== 16'h0000) begin
      n_err++;
      $display("FAIL %s_data: got %h, want 0000", tag, rd_data);
    end
    n_cmp++;
    if (fifo_count !== 4'd1) begin
      n_err++;
      $display("FAIL %s_count: got %0d, want 1", tag, fifo_count);
    end
    // Switch to manual words. The divider output is high here, so switching
    // to the low div_man creates no new rising edge. Then empty the FIFO.
    use_cnt  = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && rd_valid; i++) tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_conversion();
    logic [24:0] vin [4];
    logic [15:0] vexp [4];
    vin[0] = 25'h1000000;      vexp[0] = 16'h7FFF;
    vin[1] = 25'h0000000;      vexp[1] = 16'h8000;
    vin[2] = MIDW + 25'd256;   vexp[2] = 16'h0001;
    vin[3] = MIDW - 25'd257;   vexp[3] = 16'hFFFE;
    for (int i = 0; i < 4; i++) send(vin[i], 1'b0, 1'b0);
    n_cmp++;
    if (fifo_count !== 4'd4) begin
      n_err++;
      $display("FAIL conv_count: got %0d, want 4", fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_data !== vexp[i]) begin
        n_err++;
        $display("FAIL conv_%0d: got %h, want %h", i, rd_data, vexp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 9; k++) send(word_of(k), 1'b0, 1'b0);
    n_cmp++;
    if (fifo_count !== 4'd8 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set: got count=%0d ovf=%0b, want 8/1", fifo_count, ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %0b, want 0", ovf);
    end
    send(word_of(10), 1'b1, 1'b0);
    n_cmp++;
    if (ovf !== 1'b1 || fifo_count !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_set_wins: got ovf=%0b count=%0d, want 1/8", ovf, fifo_count);
    end
    for (int k = 1; k <= 8; k++) begin
      n_cmp++;
      if (rd_data !== 16'(k)) begin
        n_err++;
        $display("FAIL ovf_drain_%0d: got %h, want %h", k, rd_data, 16'(k));
      end
      pop_one();
    end
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_empty: rd_valid=%0b, want 0", rd_valid);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  task automatic test_full_pop();
    for (int k = 11; k <= 18; k++) send(word_of(k), 1'b0, 1'b0);
    n_cmp++;
    if (fifo_count !== 4'd8) begin
      n_err++;
      $display("FAIL full_count: got %0d, want 8", fifo_count);
    end
    send(word_of(19), 1'b0, 1'b1);
    n_cmp++;
    if (fifo_count !== 4'd8 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_pop_write: got count=%0d ovf=%0b, want 8/0", fifo_count, ovf);
    end
    for (int k = 12; k <= 19; k++) begin
      n_cmp++;
      if (rd_data !== 16'(k)) begin
        n_err++;
        $display("FAIL full_drain_%0d: got %h, want %h", k, rd_data, 16'(k));
      end
      pop_one();
    end
  endtask

  task automatic test_flush();
    for (int k = 20; k <= 28; k++) send(word_of(k), 1'b0, 1'b0);
    pop_one(); pop_one(); pop_one();
    n_cmp++;
    if (fifo_count !== 4'd5 || rd_data !== 16'd23 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL flush_pre: got count=%0d data=%h ovf=%0b, want 5/0017/1", fifo_count, rd_data, ovf);
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if (fifo_count !== 4'd0 || rd_valid !== 1'b0 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL flush: got count=%0d valid=%0b ovf=%0b, want 0/0/1", fifo_count, rd_valid, ovf);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n_cmp++;
    if (fifo_count !== 4'd0) begin
      n_err++;
      $display("FAIL empty_pop: got count=%0d, want 0", fifo_count);
    end
    enable = 1'b1;
    tick();
    for (int k = 30; k <= 32; k++) begin
      send(word_of(k), 1'b0, 1'b0);
      n_cmp++;
      if (fifo_count !== 4'd0) begin
        n_err++;
        $display("FAIL rediscard_%0d: got count=%0d, want 0", k, fifo_count);
      end
    end
    send(word_of(33), 1'b0, 1'b0);
    n_cmp++;
    if (fifo_count !== 4'd1 || rd_data !== 16'd33) begin
      n_err++;
      $display("FAIL rerun: got count=%0d data=%h, want 1/0021", fifo_count, rd_data);
    end
  endtask

  task automatic test_async_reset();
    cic_out = word_of(40);
    div_man = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_valid, rd_data, fifo_count, ovf} !== 22'h0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%0b data=%h count=%0d ovf=%0b, want all 0",
               rd_valid, rd_data, fifo_count, ovf);
    end
    cic_out = MIDW;
    div_man = 1'b0;
    use_cnt = 1'b1;
    tick(); tick(); tick();
    reset_n = 1'b1;
    test_startup("rst_recover");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_startup("startup");
    test_conversion();
    test_overflow();
    test_full_pop();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
